rename_map_table: RTL and testbench

//   Multi-lane register rename stage: maps RENAME_WIDTH instructions per cycle from arch to phys regs.

---
 rtl/rename_map_table.sv | 175 +++++++++++++++++
 tb/tb_rename_map_table.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_table.sv
// Multi-lane register rename map table: speculative map, committed map and bitmap free list.
// Optional build macro RENAME_X0_HARDWIRE_EN pins arch reg 0 to phys reg 0.
module rename_map_table #(
    parameter int ARCH_REG_NUM_WIDTH     = 5,
    parameter int PHYSICAL_REG_NUM_WIDTH = 6,
    parameter int RENAME_WIDTH           = 2,
    parameter int COMMIT_WIDTH           = 2
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             rename_valid,
    output logic                                             rename_ready,
    input  logic [RENAME_WIDTH-1:0]                          lane_regwrite,
    input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       arch_src1,
    input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       arch_src2,
    input  logic [RENAME_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       arch_dst,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   phy_src1,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   phy_src2,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   phy_dst,
    output logic [RENAME_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   phy_old_dst,
    input  logic [COMMIT_WIDTH-1:0]                          commit_valid,
    input  logic [COMMIT_WIDTH-1:0]                          commit_with_write,
    input  logic [COMMIT_WIDTH*ARCH_REG_NUM_WIDTH-1:0]       commit_arch_reg,
    input  logic [COMMIT_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   commit_new_phy,
    input  logic [COMMIT_WIDTH*PHYSICAL_REG_NUM_WIDTH-1:0]   commit_old_phy,
    input  logic                                             flush,
    output logic [PHYSICAL_REG_NUM_WIDTH:0]                  free_count
);

    localparam int A_W = ARCH_REG_NUM_WIDTH;
    localparam int P_W = PHYSICAL_REG_NUM_WIDTH;
    localparam int W   = RENAME_WIDTH;
    localparam int C   = COMMIT_WIDTH;
    localparam int A   = 1 << A_W;
    localparam int P   = 1 << P_W;
    localparam logic [P-1:0] FREE_RESET = {{(P-A){1'b1}}, {A{1'b0}}};

`ifdef RENAME_X0_HARDWIRE_EN
    localparam bit X0_HARDWIRE = 1'b1;
`else
    localparam bit X0_HARDWIRE = 1'b0;
`endif

    logic [P_W-1:0] spec_map      [A];
    logic [P_W-1:0] committed_map [A];
    logic [P-1:0]   free_list;

    logic [P_W-1:0] spec_next     [A];
    logic [P_W-1:0] comm_next     [A];
    logic [P-1:0]   free_next;
    logic [P_W-1:0] alloc         [W];
    logic [W-1:0]   lane_writes;
    logic           fire;

    function automatic logic [A_W-1:0] lane_arch(input logic [W*A_W-1:0] bus, input int k);
        return bus[k*A_W +: A_W];
    endfunction

    always_comb begin
        free_count = '0;
        for (int i = 0; i < P; i++) begin
            free_count = free_count + {{P_W{1'b0}}, free_list[i]};
        end
    end

    assign rename_ready = !flush && (free_count >= (P_W+1)'(W));
    assign fire         = rename_valid && rename_ready;

    always_comb begin
        for (int k = 0; k < W; k++) begin
            lane_writes[k] = lane_regwrite[k] &&
                             !(X0_HARDWIRE && lane_arch(arch_dst, k) == '0);
        end
    end

    // Each writing lane takes the lowest free bit still left after the older lanes picked theirs.
    always_comb begin
        logic [P-1:0] avail;
        logic         found;
        avail = free_list;
        for (int k = 0; k < W; k++) begin
            alloc[k] = '0;
            found    = 1'b0;
            if (lane_writes[k]) begin
                for (int i = 0; i < P; i++) begin
                    if (!found && avail[i]) begin
                        alloc[k] = P_W'(i);
                        avail[i] = 1'b0;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    // Later lanes see older lanes' destinations; the youngest older writer wins.
    always_comb begin
        logic [A_W-1:0] a1, a2, ad;
        phy_src1    = '0;
        phy_src2    = '0;
        phy_dst     = '0;
        phy_old_dst = '0;
        for (int j = 0; j < W; j++) begin
            a1 = lane_arch(arch_src1, j);
            a2 = lane_arch(arch_src2, j);
            ad = lane_arch(arch_dst, j);
            phy_src1[j*P_W +: P_W] = spec_map[a1];
            phy_src2[j*P_W +: P_W] = spec_map[a2];
            if (lane_writes[j]) begin
                phy_old_dst[j*P_W +: P_W] = spec_map[ad];
                phy_dst[j*P_W +: P_W]     = alloc[j];
            end
            for (int i = 0; i < j; i++) begin
                if (lane_writes[i] && lane_arch(arch_dst, i) == a1) phy_src1[j*P_W +: P_W] = alloc[i];
                if (lane_writes[i] && lane_arch(arch_dst, i) == a2) phy_src2[j*P_W +: P_W] = alloc[i];
                if (lane_writes[i] && lane_writes[j] && lane_arch(arch_dst, i) == ad)
                    phy_old_dst[j*P_W +: P_W] = alloc[i];
            end
            if (X0_HARDWIRE && a1 == '0) phy_src1[j*P_W +: P_W] = '0;
            if (X0_HARDWIRE && a2 == '0) phy_src2[j*P_W +: P_W] = '0;
        end
    end

    // Commits free regs after this cycle's allocations are removed; a flush rebuilds from the committed map.
    always_comb begin
        logic [A_W-1:0] ca;
        spec_next = spec_map;
        comm_next = committed_map;
        free_next = free_list;
        if (fire) begin
            for (int k = 0; k < W; k++) begin
                if (lane_writes[k]) begin
                    spec_next[lane_arch(arch_dst, k)] = alloc[k];
                    free_next[alloc[k]]               = 1'b0;
                end
            end
        end
        for (int c = 0; c < C; c++) begin
            ca = commit_arch_reg[c*A_W +: A_W];
            if (commit_valid[c] && commit_with_write[c] && !(X0_HARDWIRE && ca == '0)) begin
                comm_next[ca]                           = commit_new_phy[c*P_W +: P_W];
                free_next[commit_old_phy[c*P_W +: P_W]] = 1'b1;
            end
        end
        if (flush) begin
            spec_next = comm_next;
            free_next = '1;
            for (int i = 0; i < A; i++) begin
                free_next[comm_next[i]] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < A; i++) begin
                spec_map[i]      <= P_W'(i);
                committed_map[i] <= P_W'(i);
            end
            free_list <= FREE_RESET;
        end else begin
            spec_map      <= spec_next;
            committed_map <= comm_next;
            free_list     <= free_next;
        end
    end

    for (genvar c = 0; c < C; c++) begin : g_commit_chk
        assert property (@(posedge clk) disable iff (reset)
            (commit_valid[c] && commit_with_write[c] &&
             !(X0_HARDWIRE && commit_arch_reg[c*A_W +: A_W] == '0))
            |-> !free_list[commit_old_phy[c*P_W +: P_W]]);
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table: directed vector table, hand sequences, and
// randomized traffic against a lane-sequential reference model with an in-order ROB queue.
module tb_rename_map_table;

    localparam int AW = 5;
    localparam int PW = 6;
    localparam int W  = 2;
    localparam int C  = 2;
    localparam int A  = 32;
    localparam int P  = 64;

`ifdef RENAME_X0_HARDWIRE_EN
    localparam bit X0 = 1'b1;
`else
    localparam bit X0 = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            rename_valid;
    logic            rename_ready;
    logic [W-1:0]    lane_regwrite;
    logic [W*AW-1:0] arch_src1, arch_src2, arch_dst;
    logic [W*PW-1:0] phy_src1, phy_src2, phy_dst, phy_old_dst;
    logic [C-1:0]    commit_valid, commit_with_write;
    logic [C*AW-1:0] commit_arch_reg;
    logic [C*PW-1:0] commit_new_phy, commit_old_phy;
    logic            flush;
    logic [PW:0]     free_count;

    rename_map_table dut (
        .clk(clk), .reset(reset),
        .rename_valid(rename_valid), .rename_ready(rename_ready),
        .lane_regwrite(lane_regwrite),
        .arch_src1(arch_src1), .arch_src2(arch_src2), .arch_dst(arch_dst),
        .phy_src1(phy_src1), .phy_src2(phy_src2), .phy_dst(phy_dst), .phy_old_dst(phy_old_dst),
        .commit_valid(commit_valid), .commit_with_write(commit_with_write),
        .commit_arch_reg(commit_arch_reg), .commit_new_phy(commit_new_phy),
        .commit_old_phy(commit_old_phy),
        .flush(flush), .free_count(free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct { int arch; int newp; int oldp; } rob_t;
    rob_t rob[$];

    int mspec[A], mcomm[A], nspec[A];
    bit mfree[P], nfree[P];
    int e_s1[W], e_s2[W], e_dst[W], e_old[W];
    int e_fc;
    bit e_ready, e_fire;

    typedef struct {
        logic       valid; logic [1:0] rw;
        logic [9:0] s1, s2, d;  logic flush;
        logic       ready; int fc;
        logic [11:0] es1, es2, edst, eold;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < P; i++) n += int'(mfree[i]);
        return n;
    endfunction

    function automatic int lane(input logic [W*AW-1:0] bus, input int k);
        return int'(bus[k*AW +: AW]);
    endfunction

    function automatic bit writes(input int k);
        return lane_regwrite[k] && !(X0 && lane(arch_dst, k) == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < A; i++) begin mspec[i] = i; mcomm[i] = i; end
        for (int i = 0; i < P; i++) mfree[i] = (i >= A);
        rob.delete();
    endtask

    // Lanes processed one after another against a scratch copy of the map.
    task automatic model_eval();
        int a1, a2, d, pick;
        e_fc    = mcount();
        e_ready = !flush && e_fc >= W;
        e_fire  = rename_valid && e_ready;
        nspec   = mspec;
        nfree   = mfree;
        for (int k = 0; k < W; k++) begin
            a1 = lane(arch_src1, k); a2 = lane(arch_src2, k); d = lane(arch_dst, k);
            e_s1[k] = (X0 && a1 == 0) ? 0 : nspec[a1];
            e_s2[k] = (X0 && a2 == 0) ? 0 : nspec[a2];
            e_dst[k] = 0; e_old[k] = 0;
            if (writes(k)) begin
                pick = -1;
                for (int i = P - 1; i >= 0; i--) if (nfree[i]) pick = i;
                e_old[k] = nspec[d];
                e_dst[k] = (pick < 0) ? 0 : pick;
                if (pick >= 0) nfree[pick] = 1'b0;
                nspec[d] = e_dst[k];
            end
        end
    endtask

    task automatic model_update();
        int a;
        if (reset) begin model_reset(); return; end
        if (e_fire) begin
            mspec = nspec;
            mfree = nfree;
            for (int k = 0; k < W; k++)
                if (writes(k)) rob.push_back('{lane(arch_dst, k), e_dst[k], e_old[k]});
        end
        for (int c = 0; c < C; c++) begin
            a = int'(commit_arch_reg[c*AW +: AW]);
            if (commit_valid[c] && commit_with_write[c] && !(X0 && a == 0)) begin
                mcomm[a] = int'(commit_new_phy[c*PW +: PW]);
                mfree[int'(commit_old_phy[c*PW +: PW])] = 1'b1;
            end
        end
        if (flush) begin
            mspec = mcomm;
            for (int i = 0; i < P; i++) mfree[i] = 1'b1;
            for (int i = 0; i < A; i++) mfree[mcomm[i]] = 1'b0;
            rob.delete();
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] rw, input logic [9:0] s1,
                                 input logic [9:0] s2, input logic [9:0] d, input logic fl);
        rename_valid = v; lane_regwrite = rw;
        arch_src1 = s1; arch_src2 = s2; arch_dst = d; flush = fl;
        commit_valid = '0; commit_with_write = '0;
        commit_arch_reg = '0; commit_new_phy = '0; commit_old_phy = '0;
    endtask

    task automatic commit_from_rob(input int n);
        rob_t r;
        for (int c = 0; c < n && c < C; c++) begin
            if (rob.size() > 0) begin
                r = rob.pop_front();
                commit_valid[c] = 1'b1; commit_with_write[c] = 1'b1;
                commit_arch_reg[c*AW +: AW] = AW'(r.arch);
                commit_new_phy[c*PW +: PW]  = PW'(r.newp);
                commit_old_phy[c*PW +: PW]  = PW'(r.oldp);
            end
        end
    endtask

    task automatic checkOutput();
        check("ready", int'(rename_ready), int'(e_ready));
        check("free_count", int'(free_count), e_fc);
        for (int k = 0; k < W; k++) begin
            check($sformatf("src1_l%0d", k), int'(phy_src1[k*PW +: PW]), e_s1[k]);
            check($sformatf("src2_l%0d", k), int'(phy_src2[k*PW +: PW]), e_s2[k]);
            if (e_fc >= W) begin
                check($sformatf("dst_l%0d", k), int'(phy_dst[k*PW +: PW]), e_dst[k]);
                check($sformatf("old_l%0d", k), int'(phy_old_dst[k*PW +: PW]), e_old[k]);
            end
        end
    endtask

    task automatic cycle_begin();
        model_eval();
        @(negedge clk);
    endtask

    task automatic cycle_end();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic run_cycle(input bit do_check);
        cycle_begin();
        if (do_check) checkOutput();
        cycle_end();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b0);
        run_cycle(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        vec_t v;
        int nc;
        vecs[0] = '{1'b0, 2'b00, {5'd7, 5'd2}, {5'd9, 5'd31}, '0, 1'b0,
                    1'b1, 32, {6'd7, 6'd2}, {6'd9, 6'd31}, '0, '0};
        vecs[1] = '{1'b1, 2'b11, {5'd3, 5'd1}, {5'd4, 5'd6}, {5'd3, 5'd3}, 1'b0,
                    1'b1, 32, {6'd32, 6'd1}, {6'd4, 6'd6}, {6'd33, 6'd32}, {6'd32, 6'd3}};
        vecs[2] = '{1'b0, 2'b00, {5'd3, 5'd3}, {5'd1, 5'd3}, '0, 1'b0,
                    1'b1, 30, {6'd33, 6'd33}, {6'd1, 6'd33}, '0, '0};
        vecs[3] = '{1'b1, 2'b01, {5'd5, 5'd8}, {5'd3, 5'd5}, {5'd9, 5'd5}, 1'b0,
                    1'b1, 30, {6'd34, 6'd8}, {6'd33, 6'd5}, {6'd0, 6'd34}, {6'd0, 6'd5}};
        vecs[4] = '{1'b1, 2'b11, {5'd5, 5'd3}, {5'd2, 5'd2}, {5'd7, 5'd6}, 1'b1,
                    1'b0, 29, {6'd34, 6'd33}, {6'd2, 6'd2}, {6'd36, 6'd35}, {6'd7, 6'd6}};
        vecs[5] = '{1'b0, 2'b00, {5'd5, 5'd3}, {5'd9, 5'd8}, '0, 1'b0,
                    1'b1, 32, {6'd5, 6'd3}, {6'd9, 6'd8}, '0, '0};

        model_reset();
        reset_dut();

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            applyStimulus(v.valid, v.rw, v.s1, v.s2, v.d, v.flush);
            cycle_begin();
            check($sformatf("v%0d_ready", i), int'(rename_ready), int'(v.ready));
            check($sformatf("v%0d_fc", i), int'(free_count), v.fc);
            check($sformatf("v%0d_src1", i), int'(phy_src1), int'(v.es1));
            check($sformatf("v%0d_src2", i), int'(phy_src2), int'(v.es2));
            check($sformatf("v%0d_dst", i), int'(phy_dst), int'(v.edst));
            check($sformatf("v%0d_old", i), int'(phy_old_dst), int'(v.eold));
            cycle_end();
        end

        // Commit and flush in the same cycle keep the committed mapping.
        applyStimulus(1'b1, 2'b01, '0, '0, {5'd0, 5'd5}, 1'b0);
        cycle_begin(); check("cf_alloc", int'(phy_dst[0 +: PW]), 32); cycle_end();
        applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b1);
        commit_from_rob(1);
        cycle_begin(); check("cf_ready_flush", int'(rename_ready), 0); cycle_end();
        applyStimulus(1'b1, 2'b01, {5'd0, 5'd5}, '0, {5'd0, 5'd7}, 1'b0);
        cycle_begin();
        check("cf_r5", int'(phy_src1[0 +: PW]), 32);
        check("cf_fc", int'(free_count), 32);
        check("cf_realloc5", int'(phy_dst[0 +: PW]), 5);
        cycle_end();

        // Reset asserted while a group fires and commits are offered.
        applyStimulus(1'b1, 2'b11, '0, '0, {5'd9, 5'd8}, 1'b0);
        run_cycle(1'b1);
        reset = 1'b1;
        applyStimulus(1'b1, 2'b11, '0, '0, {5'd9, 5'd8}, 1'b1);
        commit_from_rob(2);
        run_cycle(1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 2'b00, {5'd8, 5'd9}, {5'd7, 5'd5}, '0, 1'b0);
        cycle_begin();
        check("rst_fc", int'(free_count), 32);
        check("rst_src1", int'(phy_src1), int'({6'd8, 6'd9}));
        check("rst_src2", int'(phy_src2), int'({6'd7, 6'd5}));
        cycle_end();

        // Exhaust the free list, then free a single reg.
        for (int g = 0; g < 16; g++) begin
            applyStimulus(1'b1, 2'b11, '0, '0, {5'd4, 5'd3}, 1'b0);
            run_cycle(1'b1);
        end
        applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b0);
        commit_from_rob(1);
        cycle_begin();
        check("ex_fc0", int'(free_count), 0);
        check("ex_ready0", int'(rename_ready), 0);
        check("ex_commit_old", int'(commit_old_phy[0 +: PW]), 3);
        cycle_end();
        applyStimulus(1'b1, 2'b11, '0, '0, {5'd4, 5'd3}, 1'b0);
        cycle_begin();
        check("ex_fc1", int'(free_count), 1);
        check("ex_ready1", int'(rename_ready), 0);
        cycle_end();

        // Arch reg 0 as destination.
        reset_dut();
        applyStimulus(1'b1, 2'b01, '0, '0, '0, 1'b0);
        cycle_begin(); check("x0_dst", int'(phy_dst[0 +: PW]), X0 ? 0 : 32); cycle_end();
        applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b0);
        cycle_begin(); check("x0_fc", int'(free_count), X0 ? 32 : 31); cycle_end();

        for (int t = 0; t < 600; t++) begin
            applyStimulus(1'($urandom_range(0, 9) < 7), 2'($urandom),
                          10'($urandom), 10'($urandom), 10'($urandom),
                          1'($urandom_range(0, 39) == 0));
            nc = $urandom_range(0, 2);
            commit_from_rob(nc);
            if (nc == 0 && $urandom_range(0, 3) == 0) begin
                commit_valid[1] = 1'b1;
                commit_arch_reg[AW +: AW] = AW'($urandom);
                commit_old_phy[PW +: PW]  = PW'($urandom);
            end
            run_cycle(1'b1);
        end

        reset_dut();
        applyStimulus(1'b0, 2'b00, '0, '0, '0, 1'b0);
        cycle_begin();
        check("end_fc", int'(free_count), 32);
        check("end_ready", int'(rename_ready), 1);
        cycle_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
